// File: rtl/rbm_iteration_scheduler_if.sv
// Handshake and result bundle between the iteration scheduler and its host.
// The host drives start/layer inputs; the scheduler drives layer reset, status and results.
interface rbm_iteration_scheduler_if #(
   parameter int unsigned output_dim  = 10,
   parameter int unsigned count_width = 12,
   parameter int unsigned idx_width   = 4
);
   logic                              start;
   logic                              layer_finish;
   logic [output_dim-1:0]             layer_sample;
   logic                              layer_reset;
   logic                              busy;
   logic                              done;
   logic [output_dim*count_width-1:0] votes;
   logic [idx_width-1:0]              class_idx;
   logic [count_width-1:0]            class_count;

   modport master (
      output start, layer_finish, layer_sample,
      input  layer_reset, busy, done, votes, class_idx, class_count
   );

   modport slave (
      input  start, layer_finish, layer_sample,
      output layer_reset, busy, done, votes, class_idx, class_count
   );
endinterface

// File: rtl/rbm_iteration_scheduler.sv
// Restarts the RBM layers once per iteration, accumulates per-class votes with
// saturation, then resolves the winner with a serial lowest-index-wins argmax.
module rbm_iteration_scheduler #(
   parameter int unsigned output_dim    = 10,
   parameter int unsigned count_width   = 12,
   parameter int unsigned idx_width     = 4,
   parameter int unsigned iteration_num = 30
) (
   input logic                  clock,
   input logic                  reset,
   rbm_iteration_scheduler_if.slave bus
);
   localparam int unsigned iter_width =
      (iteration_num == 0) ? 1 : (($clog2(iteration_num + 1) < 1) ? 1 : $clog2(iteration_num + 1));

   typedef enum logic [2:0] {
      IDLE, LAUNCH, RUN, ACCUM, ARGMAX, DONE
   } state_t;

   state_t                  state;
   logic                    layer_reset_q;
   logic                    busy_q;
   logic                    done_q;
   logic [count_width-1:0]  votes_q [output_dim];
   logic [output_dim-1:0]   capture_q;
   logic [iter_width-1:0]   iter_q;
   logic [idx_width-1:0]    scan_q;
   logic [idx_width-1:0]    class_idx_q;
   logic [count_width-1:0]  class_count_q;

   logic [count_width-1:0]  cur_vote;
   logic [iter_width-1:0]   iter_next;

   // Vote under the argmax scan pointer
   always_comb begin
      cur_vote = '0;
      for (int unsigned i = 0; i < output_dim; i++) begin
         if (scan_q == idx_width'(i)) cur_vote = votes_q[i];
      end
   end

   assign iter_next = iter_q + iter_width'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         layer_reset_q <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         capture_q     <= '0;
         iter_q        <= '0;
         scan_q        <= '0;
         class_idx_q   <= '0;
         class_count_q <= '0;
         for (int unsigned i = 0; i < output_dim; i++) votes_q[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               layer_reset_q <= 1'b1;
               done_q        <= 1'b0;
               busy_q        <= 1'b0;
               if (bus.start) begin
                  for (int unsigned i = 0; i < output_dim; i++) votes_q[i] <= '0;
                  iter_q        <= '0;
                  scan_q        <= '0;
                  class_idx_q   <= '0;
                  class_count_q <= '0;
                  busy_q        <= 1'b1;
                  state         <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (iteration_num == 0) begin
                  scan_q <= '0;
                  state  <= ARGMAX;
               end else begin
                  layer_reset_q <= 1'b0;
                  state         <= RUN;
               end
            end
            RUN: begin
               if (bus.layer_finish) begin
                  capture_q     <= bus.layer_sample;
                  layer_reset_q <= 1'b1;
                  state         <= ACCUM;
               end
            end
            ACCUM: begin
               // Saturating increment: a full counter stays full
               for (int unsigned i = 0; i < output_dim; i++) begin
                  if (capture_q[i] && (votes_q[i] != '1)) votes_q[i] <= votes_q[i] + count_width'(1);
               end
               iter_q <= iter_next;
               if (iter_next == iter_width'(iteration_num)) begin
                  scan_q <= '0;
                  state  <= ARGMAX;
               end else begin
                  state  <= LAUNCH;
               end
            end
            ARGMAX: begin
               if (scan_q == '0) begin
                  class_idx_q   <= '0;
                  class_count_q <= cur_vote;
               end else if (cur_vote > class_count_q) begin
                  class_idx_q   <= scan_q;
                  class_count_q <= cur_vote;
               end
               if (scan_q == idx_width'(output_dim - 1)) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  scan_q <= scan_q + idx_width'(1);
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               layer_reset_q <= 1'b1;
               busy_q        <= 1'b0;
               done_q        <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   assign bus.layer_reset = layer_reset_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.class_idx   = class_idx_q;
   assign bus.class_count = class_count_q;

   for (genvar g = 0; g < output_dim; g++) begin : g_votes
      assign bus.votes[g*count_width +: count_width] = votes_q[g];
   end
endmodule

// File: tb/tb_rbm_iteration_scheduler.sv
// Directed scoreboard bench: three scheduler instances (3 iterations, saturating
// 2-bit counters over 5 iterations, zero iterations) share clock and reset.
module tb_rbm_iteration_scheduler;
   localparam int unsigned od = 10;

   typedef struct packed {
      logic [od-1:0][11:0] votes;
      logic [3:0]          idx;
      logic [11:0]         cnt;
      logic [15:0]         lat;
   } exp_t;

   logic clk;
   logic rst;

   rbm_iteration_scheduler_if #(.output_dim(od), .count_width(12), .idx_width(4)) m_if ();
   rbm_iteration_scheduler_if #(.output_dim(od), .count_width(2),  .idx_width(4)) s_if ();
   rbm_iteration_scheduler_if #(.output_dim(od), .count_width(12), .idx_width(4)) z_if ();

   rbm_iteration_scheduler #(.output_dim(od), .count_width(12), .idx_width(4), .iteration_num(3))
      u_main (.clock(clk), .reset(rst), .bus(m_if));
   rbm_iteration_scheduler #(.output_dim(od), .count_width(2), .idx_width(4), .iteration_num(5))
      u_sat (.clock(clk), .reset(rst), .bus(s_if));
   rbm_iteration_scheduler #(.output_dim(od), .count_width(12), .idx_width(4), .iteration_num(0))
      u_zero (.clock(clk), .reset(rst), .bus(z_if));

   logic          start_v [3];
   logic          fin_v   [3];
   logic [od-1:0] samp_v  [3];
   logic          lr_v    [3];
   logic          busy_v  [3];
   logic          done_v  [3];
   logic [3:0]    idx_v   [3];
   logic [11:0]   cnt_v   [3];
   logic [11:0]   vote_v  [3][od];

   assign m_if.start = start_v[0];  assign m_if.layer_finish = fin_v[0];  assign m_if.layer_sample = samp_v[0];
   assign s_if.start = start_v[1];  assign s_if.layer_finish = fin_v[1];  assign s_if.layer_sample = samp_v[1];
   assign z_if.start = start_v[2];  assign z_if.layer_finish = fin_v[2];  assign z_if.layer_sample = samp_v[2];

   assign lr_v[0] = m_if.layer_reset;  assign busy_v[0] = m_if.busy;  assign done_v[0] = m_if.done;
   assign lr_v[1] = s_if.layer_reset;  assign busy_v[1] = s_if.busy;  assign done_v[1] = s_if.done;
   assign lr_v[2] = z_if.layer_reset;  assign busy_v[2] = z_if.busy;  assign done_v[2] = z_if.done;
   assign idx_v[0] = m_if.class_idx;   assign cnt_v[0] = m_if.class_count;
   assign idx_v[1] = s_if.class_idx;   assign cnt_v[1] = 12'(s_if.class_count);
   assign idx_v[2] = z_if.class_idx;   assign cnt_v[2] = z_if.class_count;

   for (genvar g = 0; g < od; g++) begin : g_vote_taps
      assign vote_v[0][g] = m_if.votes[g*12 +: 12];
      assign vote_v[1][g] = 12'(s_if.votes[g*2 +: 2]);
      assign vote_v[2][g] = z_if.votes[g*12 +: 12];
   end

   int          checks;
   int          failures;
   exp_t        sb [$];
   exp_t        last_exp;
   logic [od-1:0] pat [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      checks++;
      assert (obs === exp_val) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
      end
   endtask

   // One classification on instance sel using pat[0..n-1]; optional RUN stall,
   // stray start pulses, or a reset abort when iteration abort_it reaches RUN.
   task automatic run(input int sel, input int n, input int cw, input int stall,
                      input bit inject, input int abort_it);
      exp_t e;
      int   mv [od];
      int   maxv;
      int   lat;
      int   it;
      int   stall_left;
      int   lr0_cnt;
      int   inj;
      maxv = (1 << cw) - 1;
      e = '0;
      for (int i = 0; i < od; i++) mv[i] = 0;
      for (int t = 0; t < n; t++)
         for (int i = 0; i < od; i++)
            if (pat[t][i] && mv[i] < maxv) mv[i]++;
      e.idx = 4'd0;
      e.cnt = 12'(mv[0]);
      for (int k = 1; k < od; k++)
         if (mv[k] > int'(e.cnt)) begin e.idx = 4'(k); e.cnt = 12'(mv[k]); end
      for (int i = 0; i < od; i++) e.votes[i] = 12'(mv[i]);
      // LAUNCH+RUN+ACCUM per iteration (lone LAUNCH when n==0), scan, DONE
      e.lat = 16'(((n == 0) ? 1 : 3 * n) + od + 1 + stall);
      sb.push_back(e);

      @(negedge clk); start_v[sel] = 1'b1;
      @(posedge clk); #1; start_v[sel] = 1'b0;
      lat = 1; it = 0; stall_left = stall; lr0_cnt = 0; inj = 0;
      while (!done_v[sel] && lat < 400) begin
         fin_v[sel] = 1'b0;
         start_v[sel] = 1'b0;
         if (inj > 0) begin start_v[sel] = 1'b1; inj--; end
         if (!lr_v[sel] && it < n) begin
            if (it == abort_it) begin
               rst = 1'b1;
               #1;
               for (int i = 0; i < od; i++) check($sformatf("abort_vote%0d", i), 32'(vote_v[sel][i]), 32'd0);
               check("abort_layer_reset", 32'(lr_v[sel]), 32'd1);
               check("abort_busy", 32'(busy_v[sel]), 32'd0);
               void'(sb.pop_back());
               @(negedge clk); rst = 1'b0;
               @(negedge clk);
               check("abort_idle_layer_reset", 32'(lr_v[sel]), 32'd1);
               return;
            end
            if (stall_left > 0) begin
               stall_left--;
               lr0_cnt++;
            end else begin
               fin_v[sel]  = 1'b1;
               samp_v[sel] = pat[it];
               if (inject && it == 1) begin start_v[sel] = 1'b1; inj = 1; end
               it++;
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      fin_v[sel] = 1'b0;
      start_v[sel] = 1'b0;
      if (stall > 0) check("stall_run_cycles", 32'(lr0_cnt), 32'(stall));
      if (!done_v[sel]) begin
         check("done_timeout", 32'(done_v[sel]), 32'd1);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      last_exp = e;
      for (int i = 0; i < od; i++) check($sformatf("s%0d_vote%0d", sel, i), 32'(vote_v[sel][i]), 32'(e.votes[i]));
      check($sformatf("s%0d_class_idx", sel), 32'(idx_v[sel]), 32'(e.idx));
      check($sformatf("s%0d_class_count", sel), 32'(cnt_v[sel]), 32'(e.cnt));
      check($sformatf("s%0d_latency", sel), 32'(lat), 32'(e.lat));
      check($sformatf("s%0d_busy_in_done", sel), 32'(busy_v[sel]), 32'd1);
      @(posedge clk); #1;
      check($sformatf("s%0d_done_pulse", sel), 32'(done_v[sel]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("s%0d_idle_busy", sel), 32'(busy_v[sel]), 32'd0);
      check($sformatf("s%0d_idle_done", sel), 32'(done_v[sel]), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      last_exp = '0;
      for (int s = 0; s < 3; s++) begin start_v[s] = 1'b1; fin_v[s] = 1'b0; samp_v[s] = '0; end
      for (int t = 0; t < 8; t++) pat[t] = '0;

      // Reset held with start high
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst%0d_layer_reset", s), 32'(lr_v[s]), 32'd1);
         check($sformatf("rst%0d_busy", s), 32'(busy_v[s]), 32'd0);
         check($sformatf("rst%0d_done", s), 32'(done_v[s]), 32'd0);
         check($sformatf("rst%0d_class_idx", s), 32'(idx_v[s]), 32'd0);
      end
      for (int i = 0; i < od; i++) check($sformatf("rst_vote%0d", i), 32'(vote_v[0][i]), 32'd0);
      @(negedge clk);
      for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy_v[0]), 32'd0);
      check("post_rst_layer_reset", 32'(lr_v[0]), 32'd1);

      // Basic accumulation
      pat[0] = 10'b0000000100; pat[1] = 10'b0000000110; pat[2] = 10'b0000000100;
      run(0, 3, 12, 0, 1'b0, -1);

      // layer_finish while idle must not touch the votes
      @(negedge clk); fin_v[0] = 1'b1; samp_v[0] = '1;
      repeat (3) @(negedge clk);
      fin_v[0] = 1'b0;
      for (int i = 0; i < od; i++) check($sformatf("idle_finish_vote%0d", i), 32'(vote_v[0][i]), 32'(last_exp.votes[i]));
      check("idle_finish_busy", 32'(busy_v[0]), 32'd0);

      // Tie between classes 3 and 7
      pat[0] = 10'b0010001000; pat[1] = 10'b0010001001; pat[2] = 10'b0000000010;
      run(0, 3, 12, 0, 1'b0, -1);

      // Saturating 2-bit counters
      for (int t = 0; t < 5; t++) pat[t] = 10'b0000000001;
      pat[2] = 10'b0000010001;
      run(1, 5, 2, 0, 1'b0, -1);

      // Stray start pulses in RUN/ACCUM plus a 50-cycle finish stall
      pat[0] = 10'b1000000000; pat[1] = 10'b1000000001; pat[2] = 10'b1000000000;
      run(0, 3, 12, 50, 1'b1, -1);

      // Abort in the third RUN, then a clean classification
      pat[0] = 10'b0000110000; pat[1] = 10'b0000010000; pat[2] = 10'b0000010000;
      run(0, 3, 12, 0, 1'b0, 2);
      pat[0] = 10'b0000010000; pat[1] = 10'b0000110000; pat[2] = 10'b0000010000;
      run(0, 3, 12, 0, 1'b0, -1);

      // Zero-iteration instance
      run(2, 0, 12, 0, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
